// File: rtl/reg_file16_if.sv
// reg_file16_if: bus bundle for the reg_file16 register file.
//   wf        write flag, write wd to entry wa at the rising edge
//   wa, wd    write address / write data
//   ra1, ra2  read addresses for the two combinational read ports
//   rd1, rd2  read data (combinational, with write-to-read bypass)
//   clr       start the sequential clear of all entries
//   busy      high while the clear sequence runs
// The master modport drives requests; the slave modport is the register file.
interface reg_file16_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             wf;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             clr;
  logic             busy;

  modport master (
    output wf, wa, wd, ra1, ra2, clr,
    input  rd1, rd2, busy
  );

  modport slave (
    input  wf, wa, wd, ra1, ra2, clr,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/reg_file16.sv
// reg_file16: parametrised register file with one write port, two
// combinational read ports with write-to-read bypass, an optional
// hardwired-zero entry 0, and a clear engine that zeroes one entry per
// cycle on request.
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  synchronous, active-high reset (zeroes every entry, FSM to idle)
//   bus  reg_file16_if.slave: wf/wa/wd write port, ra1/ra2 -> rd1/rd2 read
//        ports, clr request and busy status
module reg_file16 #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_file16_if.slave bus
);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             busy;
  logic             we;

  assign busy     = (state_q == CLEARING);
  assign bus.busy = busy;

  // A write is accepted only outside the clear sequence and never to a
  // hardwired-zero entry 0; the same term qualifies the bypass path.
  assign we = bus.wf && !busy && !((ZERO_REG != 0) && (bus.wa == '0));

  // Bypass: a pending accepted write is visible on the read port in the
  // same cycle, so stale contents never leak out.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    if ((ZERO_REG != 0) && (ra == '0))
      return '0;
    else if (we && (bus.wa == ra))
      return bus.wd;
    else
      return mem[ra];
  endfunction

  assign bus.rd1 = read_port(bus.ra1);
  assign bus.rd2 = read_port(bus.ra2);

  // NOTE: the storage is a flop array, not a RAM macro, because the reset
  // has to zero every entry in a single edge; a RAM could not do that.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[cnt_q] <= '0;
    end else if (we) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults come first so no path through the case leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.clr) state_d = CLEARING;
      end
      CLEARING: begin
        // clr is ignored here; the counter wraps to 0 exactly as the
        // sequence ends.
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16: directed self-checking bench for reg_file16. Instantiates a
// ZERO_REG=1 build (main) and a ZERO_REG=0 build (for the zero-entry case).
// Inputs change 1 time unit after the rising edge; outputs are checked once
// they have settled, well before the next edge.
module tb_reg_file16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file16_if #(.WIDTH(16), .AW(4)) bus   ();
  reg_file16_if #(.WIDTH(16), .AW(4)) bus_z ();

  reg_file16 #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  reg_file16 #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts the cycles busy stays high (bounded), pulsing clr on the given
  // busy cycles to show redundant requests are ignored.
  task automatic count_busy(input int clr_a, input int clr_b, output int n);
    n = 0;
    for (int c = 1; c <= 40 && bus.busy; c++) begin
      n++;
      bus.clr = (c == clr_a) || (c == clr_b);
      tick();
      bus.clr = 1'b0;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1;
    bus.wf = 0;   bus.wa = 0;   bus.wd = 0;   bus.ra1 = 0;   bus.ra2 = 0;
    bus.clr = 0;
    bus_z.wf = 0; bus_z.wa = 0; bus_z.wd = 0; bus_z.ra1 = 0; bus_z.ra2 = 0;
    bus_z.clr = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    bus.ra1 = 3; bus.ra2 = 9; bus_z.ra1 = 0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_rd1", bus.rd1, 16'h0000);
    check("rst_rd2", bus.rd2, 16'h0000);
    check("rst_z_rd1", bus_z.rd1, 16'h0000);

    // Write then read
    bus.wf = 1; bus.wa = 3; bus.wd = 16'h1234;
    tick();
    bus.wf = 0; bus.ra1 = 3; bus.ra2 = 4;
    #1;
    check("wr_rd1", bus.rd1, 16'h1234);
    check("wr_rd2", bus.rd2, 16'h0000);

    // WF low holds contents
    bus.wd = 16'h4321; bus.wa = 3;
    tick();
    tick();
    check("hold_rd1", bus.rd1, 16'h1234);

    // Bypass
    bus.wf = 1; bus.wa = 5; bus.wd = 16'hBEEF; bus.ra1 = 5; bus.ra2 = 3;
    #1;
    check("byp_rd1", bus.rd1, 16'hBEEF);
    check("byp_other", bus.rd2, 16'h1234);
    tick();
    bus.wf = 0;
    #1;
    check("byp_after", bus.rd1, 16'hBEEF);

    // Zero register: ZERO_REG=1 ignores, ZERO_REG=0 stores
    bus.wf = 1;   bus.wa = 0;   bus.wd = 16'hFFFF;   bus.ra1 = 0;
    bus_z.wf = 1; bus_z.wa = 0; bus_z.wd = 16'hFFFF; bus_z.ra1 = 0;
    #1;
    check("zr_during", bus.rd1, 16'h0000);
    check("zr0_during", bus_z.rd1, 16'hFFFF);
    tick();
    bus.wf = 0; bus_z.wf = 0;
    #1;
    check("zr_after", bus.rd1, 16'h0000);
    check("zr0_after", bus_z.rd1, 16'hFFFF);

    // Clear sequence
    for (int a = 1; a < 16; a++) begin
      bus.wf = 1; bus.wa = 4'(a); bus.wd = 16'(a);
      tick();
    end
    bus.wf = 0;
    bus.clr = 1;
    tick();
    bus.clr = 0;
    bus.ra1 = 12;
    n = 0;
    for (int c = 1; c <= 40 && bus.busy; c++) begin
      n++;
      if (c == 8) begin
        bus.wf = 1; bus.wa = 12; bus.wd = 16'hAAAA;
        #1;
        check("clr_mid_nobyp", bus.rd1, 16'h000C);
      end
      if (c == 9) check("clr_wr_dropped", bus.rd1, 16'h000C);
      tick();
      bus.wf = 0;
    end
    check("clr_busy_len", n, 16);
    for (int a = 0; a < 16; a++) begin
      bus.ra1 = 4'(a); bus.ra2 = 4'(15 - a);
      #1;
      check($sformatf("clr_zero_%0d", a), bus.rd1, 16'h0000);
      check($sformatf("clr_zero2_%0d", a), bus.rd2, 16'h0000);
    end

    // Reset mid-clear
    bus.wf = 1; bus.wa = 10; bus.wd = 16'h5555;
    tick();
    bus.wf = 0; bus.clr = 1;
    tick();
    bus.clr = 0; bus.ra1 = 10;
    tick();
    tick();
    tick();
    check("rmc_busy_c4", bus.busy, 1);
    check("rmc_old", bus.rd1, 16'h5555);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rmc_busy", bus.busy, 0);
    check("rmc_rd1", bus.rd1, 16'h0000);

    // Simultaneous CLR + WF in IDLE
    bus.wf = 1; bus.clr = 1; bus.wa = 7; bus.wd = 16'h7777; bus.ra1 = 7;
    tick();
    bus.wf = 0; bus.clr = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check($sformatf("sim_c%0d", c), bus.rd1, (c <= 8) ? 16'h7777 : 16'h0000);
      tick();
    end
    count_busy(0, 0, n);
    check("sim_busy_len", n, 6);

    // Redundant CLR during BUSY
    bus.clr = 1;
    tick();
    bus.clr = 0;
    count_busy(5, 16, n);
    check("redund_len", n, 16);
    tick();
    check("redund_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
